// File: rtl/uart_rx_if.sv
// uart_rx consumer-side bundle: receive enable in, byte and status pulses out.
interface uart_rx_if #(
  parameter int PAYLOAD_BITS = 8
);
  logic                    uart_rx_en;
  logic                    uart_rx_valid;
  logic [PAYLOAD_BITS-1:0] uart_rx_data;
  logic                    uart_rx_frame_err;
  logic                    uart_rx_break;

  modport master (
    output uart_rx_en,
    input  uart_rx_valid,
    input  uart_rx_data,
    input  uart_rx_frame_err,
    input  uart_rx_break
  );

  modport slave (
    input  uart_rx_en,
    output uart_rx_valid,
    output uart_rx_data,
    output uart_rx_frame_err,
    output uart_rx_break
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: oversampled 8N1-style framing, mid-bit sampling,
// one-cycle valid / frame error / break pulses.
module uart_rx #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 500000,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic     clk,
  input  logic     resetn,
  input  logic     uart_rxd,
  uart_rx_if.slave rx
);
  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int CW = $clog2(CYCLES_PER_BIT);
  localparam int IW = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

  typedef enum logic [2:0] {
    IDLE, START, RECV, STOP, WAIT_HIGH
  } state_t;

  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [IW-1:0]           idx, idx_n;
  logic [PAYLOAD_BITS-1:0] sr, sr_n;
  logic [PAYLOAD_BITS-1:0] data_q, data_n;
  logic                    valid_q, valid_n;
  logic                    ferr_q, ferr_n;
  logic                    brk_q, brk_n;
  logic [1:0]              sync;
  logic                    rxd_s;

  assign rxd_s = sync[1];

  // Synchroniser resets to the idle level so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (!resetn) sync <= 2'b11;
    else         sync <= {sync[0], uart_rxd};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      sr      <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      sr      <= sr_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      ferr_q  <= ferr_n;
      brk_q   <= brk_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sr_n    = sr;
    data_n  = data_q;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    brk_n   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (rx.uart_rx_en && !rxd_s) state_n = START;
      end
      START: begin
        if (cnt == CW'(HALF_BIT - 1)) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rxd_s ? IDLE : RECV;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      RECV: begin
        if (cnt == CW'(CYCLES_PER_BIT - 1)) begin
          cnt_n = '0;
          // LSB arrives first, so shift in from the top
          sr_n  = (sr >> 1) |
                  (PAYLOAD_BITS'(rxd_s) << (PAYLOAD_BITS - 1));
          if (idx == IW'(PAYLOAD_BITS - 1)) state_n = STOP;
          else                              idx_n   = idx + IW'(1);
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (cnt == CW'(CYCLES_PER_BIT - 1)) begin
          cnt_n = '0;
          if (rxd_s) begin
            data_n  = sr;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            brk_n   = (sr == '0);
            state_n = WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      WAIT_HIGH: begin
        if (rxd_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign rx.uart_rx_valid     = valid_q;
  assign rx.uart_rx_data      = data_q;
  assign rx.uart_rx_frame_err = ferr_q;
  assign rx.uart_rx_break     = brk_q;
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, the receive-side counterpart of the team's uart_tx. Format is 8N1 by default: line idle high, one start bit (low), PAYLOAD_BITS data bits sent LSB first, and one stop bit (high). The block oversamples the asynchronous uart_rxd pin with the system clock and samples each bit at mid-bit. It delivers each received byte with a single-cycle valid strobe, so a top-level controller can consume host commands over the same serial link the transmitter drives.

Parameters:
- BIT_RATE, 9600, line rate in bits/s.
- CLK_HZ, 500000, clk frequency in Hz.
- PAYLOAD_BITS, 8, data bits per frame (1..8).
- CYCLES_PER_BIT, derived = CLK_HZ/BIT_RATE (integer division; 52 at defaults). Must be >= 4.
- HALF_BIT, derived = CYCLES_PER_BIT/2 (26 at defaults).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- uart_rxd  in  1  asynchronous serial input; idles high.
- uart_rx_en  in  1  enables start-bit detection.
- uart_rx_valid  out  1  one-cycle pulse: uart_rx_data holds a new, good frame.
- uart_rx_data  out  PAYLOAD_BITS  last good received payload.
- uart_rx_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- uart_rx_break  out  1  one-cycle pulse: frame error with all data bits 0.

Behaviour:
- Reset: one clock is used, and reset is synchronous and active-low (resetn sampled on the rising clk edge).
  - While resetn=0 at an edge: state=IDLE, counters=0, shift register=0.
  - Both synchroniser flops are set to 1.
  - uart_rx_valid=0, uart_rx_frame_err=0, uart_rx_break=0, uart_rx_data=0.
  - Reset mid-frame abandons the frame with no pulse.
- Synchroniser: 2-flop, producing rxd_s. All decisions use rxd_s only.
- State machine:
  - IDLE: if uart_rx_en=1 and rxd_s=0, go to START with the cycle counter at 0. Otherwise stay.
  - START: spends HALF_BIT cycles; rxd_s is sampled on the last of them.
    - Sample 0: go to RECV, counter=0, bit index=0.
    - Sample 1: glitch; return to IDLE with no outputs.
  - RECV: each data bit occupies CYCLES_PER_BIT cycles; rxd_s is sampled when counter=CYCLES_PER_BIT-1.
    - The sampled bit is shifted in from the MSB side, so the first bit received ends at data[0].
    - After PAYLOAD_BITS samples, go to STOP.
  - STOP: spends CYCLES_PER_BIT cycles and samples rxd_s on the last one.
    - Sample 1: uart_rx_data <= shift register, uart_rx_valid=1 for exactly one cycle, go to IDLE.
    - Sample 0: uart_rx_frame_err=1 for one cycle. uart_rx_break=1 in the same cycle if the shift register is all 0. uart_rx_data is NOT updated. Go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxd_s=1, then go to IDLE. This prevents a held break from re-triggering frames.
- uart_rx_en:
  - Gates only the IDLE->START transition.
  - Deasserting it mid-frame does not abort; the current frame completes normally.
- Latency: let edge k be the first edge at which the first synchroniser flop captures the start-bit 0.
  - uart_rx_valid is high in the cycle after edge k+2+HALF_BIT+(PAYLOAD_BITS+1)*CYCLES_PER_BIT.
  - At defaults that is edge k+496.
- Back-to-back frames: a new start bit is accepted on the first IDLE cycle after a valid pulse. No gap beyond the stop bit is needed.
- Pulse exclusivity: uart_rx_valid and uart_rx_frame_err are never high in the same cycle.
- Hold: uart_rx_data holds its value between valid pulses.
- Rate tolerance: the counter restarts at each bit boundary, with no cumulative rounding beyond integer division. The receiver tolerates ±2% rate mismatch at defaults.

Test Plan:
- Single byte: reset, uart_rx_en=1, drive 0x48 as a bit-accurate 8N1 frame (52 clk per bit) -> one valid pulse at edge k+496, uart_rx_data=0x48, no frame_err.
- Back-to-back stream: send "Hello World!\n" (13 bytes) with no idle gap -> 13 valid pulses in order with the matching bytes; no errors.
- Glitch: pulse uart_rxd low for 10 cycles -> returns to IDLE; no valid, frame_err or break; uart_rx_data unchanged.
- Frame error: byte 0x55 with stop bit driven 0 -> frame_err pulse only, break=0, uart_rx_data keeps its prior value. Then hold uart_rxd low for 1000 cycles, then release and send 0xA3 -> exactly one valid with 0xA3.
- Break and enable: hold uart_rxd low for 20 bit times -> one frame_err and one break pulse together, then no further pulses. With uart_rx_en=0, send a frame -> no pulses. Set uart_rx_en=1 mid-frame -> still no pulse for that frame.
- Reset mid-frame: assert resetn=0 for 1 cycle during bit 4 of 0xFF -> no pulse, uart_rx_data=0. The next clean frame 0x0F is received correctly.
